// File: rtl/fir_decimator.sv
// -----------------------------------------------------------------------------
// fir_decimator
//
// Block-average decimator placed behind an FIR stage. Every DECIM accepted
// input samples are summed, rounded (half-up on the arithmetic shift),
// divided by DECIM and presented as one output word on an AXI-Stream style
// master port. A 16-bit wrapping counter reports how many decimated words
// have been handed downstream.
//
// Parameters
//   DECIM   decimation factor, power of two in 2..16
//   DATA_W  sample width, signed two's complement
//
// Ports
//   aclk                single clock, rising-edge active
//   aresetn             asynchronous active-low reset
//   s_axis_data_tvalid  upstream sample valid
//   s_axis_data_tready  block can accept a sample (combinational)
//   s_axis_data_tdata   upstream filtered sample
//   m_axis_data_tvalid  decimated word valid (registered)
//   m_axis_data_tready  downstream accepts the decimated word
//   m_axis_data_tdata   decimated, averaged word (registered)
//   out_count           number of decimated words transferred, wrapping
// -----------------------------------------------------------------------------
module fir_decimator #(
  parameter int DECIM  = 4,
  parameter int DATA_W = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  input  logic [DATA_W-1:0] s_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic [DATA_W-1:0] m_axis_data_tdata,
  output logic [15:0]       out_count
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  localparam int SHIFT = $clog2(DECIM);
  // Accumulator holds up to DECIM samples without overflow.
  localparam int ACC_W = DATA_W + SHIFT;
  // One extra bit so the rounding constant can never wrap the final sum.
  localparam int SUM_W = ACC_W + 1;

  localparam logic [SHIFT-1:0] PHASE_LAST = SHIFT'(DECIM - 1);
  localparam logic [SHIFT-1:0] PHASE_ZERO = {SHIFT{1'b0}};
  localparam logic [SHIFT-1:0] PHASE_ONE  = SHIFT'(1'b1);

  // Half an LSB of the shifted result, giving round-half-up.
  localparam logic signed [SUM_W-1:0] ROUND_C = SUM_W'(DECIM / 2);

  // Output range limits expressed at the wide sum width.
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  localparam logic signed [ACC_W-1:0] ACC_ZERO  = {ACC_W{1'b0}};
  localparam logic [DATA_W-1:0]       DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [15:0]             CNT_ZERO  = 16'd0;
  localparam logic [15:0]             CNT_ONE   = 16'd1;

  // ---------------------------------------------------------------------------
  // Clamp a wide signed value into the DATA_W signed range. With legal inputs
  // the averaged result always fits; the clamp only guards against surprises.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] sat_fn(input logic signed [SUM_W-1:0] v);
    logic [DATA_W-1:0] res;
    if (v > SAT_MAX) begin
      res = SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      res = SAT_MIN[DATA_W-1:0];
    end else begin
      res = v[DATA_W-1:0];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SHIFT-1:0]        phase_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                    m_valid_r;
  logic [DATA_W-1:0]       m_data_r;
  logic [15:0]             out_count_r;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic                    s_ready_s;
  logic                    in_xfer_s;
  logic                    out_xfer_s;
  logic                    group_done_s;
  logic signed [ACC_W-1:0] sample_acc_s;
  logic signed [SUM_W-1:0] sample_sum_s;
  logic signed [SUM_W-1:0] final_sum_s;
  logic signed [SUM_W-1:0] shifted_s;
  logic [SHIFT-1:0]        phase_nxt_s;
  logic signed [ACC_W-1:0] acc_nxt_s;
  logic                    m_valid_nxt_s;
  logic [DATA_W-1:0]       m_data_nxt_s;
  logic [15:0]             out_count_nxt_s;

  // Upstream may push whenever the output slot is empty or being drained this
  // cycle; the output register is the only stall source.
  assign s_ready_s  = !m_valid_r || m_axis_data_tready;
  assign in_xfer_s  = s_axis_data_tvalid && s_ready_s;
  assign out_xfer_s = m_valid_r && m_axis_data_tready;

  // A group completes on the transfer that carries its last sample.
  assign group_done_s = in_xfer_s && (phase_r == PHASE_LAST);

  // Sample sign-extended to accumulator and final-sum widths.
  assign sample_acc_s = {{SHIFT{s_axis_data_tdata[DATA_W-1]}}, s_axis_data_tdata};
  assign sample_sum_s = {{(SHIFT+1){s_axis_data_tdata[DATA_W-1]}}, s_axis_data_tdata};

  // Full group sum with the rounding offset, then divide by DECIM.
  assign final_sum_s = {acc_r[ACC_W-1], acc_r} + sample_sum_s + ROUND_C;
  assign shifted_s   = final_sum_s >>> SHIFT;

  // Phase counter and accumulator next state.
  always_comb begin
    phase_nxt_s = phase_r;
    acc_nxt_s   = acc_r;
    if (in_xfer_s) begin
      if (phase_r == PHASE_LAST) begin
        // Group closed: its contents move to the output register this edge.
        phase_nxt_s = PHASE_ZERO;
        acc_nxt_s   = ACC_ZERO;
      end else begin
        phase_nxt_s = phase_r + PHASE_ONE;
        acc_nxt_s   = acc_r + sample_acc_s;
      end
    end else begin
      phase_nxt_s = phase_r;
      acc_nxt_s   = acc_r;
    end
  end

  // Output register next state; a completing group wins over a drain so a
  // back-to-back word keeps valid high with no bubble.
  always_comb begin
    m_valid_nxt_s = m_valid_r;
    m_data_nxt_s  = m_data_r;
    if (group_done_s) begin
      m_valid_nxt_s = 1'b1;
      m_data_nxt_s  = sat_fn(shifted_s);
    end else if (out_xfer_s) begin
      m_valid_nxt_s = 1'b0;
      m_data_nxt_s  = m_data_r;
    end else begin
      m_valid_nxt_s = m_valid_r;
      m_data_nxt_s  = m_data_r;
    end
  end

  // Transfer counter next state, wrapping at 16 bits.
  always_comb begin
    out_count_nxt_s = out_count_r;
    if (out_xfer_s) begin
      out_count_nxt_s = out_count_r + CNT_ONE;
    end else begin
      out_count_nxt_s = out_count_r;
    end
  end

  // State registers; reset drops any partial group and any pending word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_r     <= PHASE_ZERO;
      acc_r       <= ACC_ZERO;
      m_valid_r   <= 1'b0;
      m_data_r    <= DATA_ZERO;
      out_count_r <= CNT_ZERO;
    end else begin
      phase_r     <= phase_nxt_s;
      acc_r       <= acc_nxt_s;
      m_valid_r   <= m_valid_nxt_s;
      m_data_r    <= m_data_nxt_s;
      out_count_r <= out_count_nxt_s;
    end
  end

  assign s_axis_data_tready = s_ready_s;
  assign m_axis_data_tvalid = m_valid_r;
  assign m_axis_data_tdata  = m_data_r;
  assign out_count          = out_count_r;

endmodule

// File: tb/tb_fir_decimator.sv
// -----------------------------------------------------------------------------
// tb_fir_decimator
//
// Directed-vector bench for fir_decimator (DECIM=4, DATA_W=16). Stimulus
// pushes hand-computed expected words into a queue; a monitor pops and
// compares on every output transfer. The main thread adds direct checks on
// handshake behaviour, reset values and the transfer counter.
// -----------------------------------------------------------------------------
module tb_fir_decimator;

  logic        aclk;
  logic        aresetn;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] m_tdata;
  logic [15:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;
  int exp_q[$];

  fir_decimator #(.DECIM(4), .DATA_W(16)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .s_axis_data_tdata  (s_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .m_axis_data_tdata  (m_tdata),
    .out_count          (out_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: inputs are stable at the falling edge, so a visible handshake
  // here is the transfer the next rising edge will perform.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", $signed(m_tdata), 99999);
      end else begin
        check("scoreboard_data", int'($signed(m_tdata)), exp_q.pop_front());
      end
    end
  end

  // Present one sample and hold it until accepted (bounded wait).
  task automatic send(input int v);
    int w;
    w = 0;
    s_tvalid = 1'b1;
    s_tdata  = 16'(v);
    @(negedge aclk);
    while (!s_tready && w < 100) begin
      w++;
      stall_cnt++;
      @(negedge aclk);
    end
    if (w >= 100) check("send_timeout", w, 0);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 16'd0;
    m_tready = 1'b1;

    // Reset state
    #3;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_out_count", out_count, 0);
    check("rst_s_tready", s_tready, 1);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("post_rst_s_tready", s_tready, 1);
    check("post_rst_m_tvalid", m_tvalid, 0);

    // Basic average: 100..400 -> 250, valid for exactly one cycle
    exp_q.push_back(250);
    send4(100, 200, 300, 400);
    check("basic_valid_hi", m_tvalid, 1);
    idle(1);
    check("basic_valid_one_cycle", m_tvalid, 0);
    check("basic_out_count", out_count, 1);

    // Negative rounding: -5+2 >>> 2 = -1 ; 5+2 >>> 2 = 1
    exp_q.push_back(-1);
    send4(-1, -1, -1, -2);
    exp_q.push_back(1);
    send4(1, 1, 1, 2);
    idle(2);
    check("round_out_count", out_count, 3);

    // Extremes: no wrap at either end of the range
    exp_q.push_back(32767);
    send4(32767, 32767, 32767, 32767);
    exp_q.push_back(-32768);
    send4(-32768, -32768, -32768, -32768);
    idle(2);
    check("extreme_out_count", out_count, 5);

    // Continuous ramp 0..15 -> 2,6,10,14 with no input stalls
    stall_cnt = 0;
    exp_q.push_back(2);
    exp_q.push_back(6);
    exp_q.push_back(10);
    exp_q.push_back(14);
    for (int i = 0; i < 16; i++) send(i);
    check("ramp_no_stall", stall_cnt, 0);
    idle(2);
    check("ramp_out_count", out_count, 9);

    // Backpressure: 250 held for 10 cycles, offered samples ignored
    m_tready = 1'b0;
    exp_q.push_back(250);
    send4(100, 200, 300, 400);
    s_tvalid = 1'b1;
    s_tdata  = 16'h7777;
    for (int i = 0; i < 10; i++) begin
      check("stall_s_tready", s_tready, 0);
      check("stall_m_tvalid", m_tvalid, 1);
      check("stall_m_tdata", m_tdata, 250);
      idle(1);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    idle(1);
    check("stall_release_valid", m_tvalid, 0);
    check("stall_release_count", out_count, 10);
    exp_q.push_back(4);
    send4(4, 4, 4, 4);
    idle(2);
    check("stall_after_count", out_count, 11);

    // Mid-cycle reset drops a partial group
    send(1000); send(1000); send(1000);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_m_tdata", m_tdata, 0);
    check("mid_rst_out_count", out_count, 0);
    check("mid_rst_s_tready", s_tready, 1);
    idle(2);
    check("mid_rst_hold_m_tvalid", m_tvalid, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    exp_q.push_back(8);
    send4(8, 8, 8, 8);
    check("after_rst_m_tdata", m_tdata, 8);
    idle(2);
    check("after_rst_out_count", out_count, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 SHALL have parameter DECIM, default 4: decimation factor, a power of two in 2..16.
REQ-002 SHALL have parameter DATA_W, default 16: sample width, signed two's complement.
REQ-003 SHALL have port aclk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port s_axis_data_tvalid, input, 1: upstream FIR output sample valid.
REQ-006 SHALL have port s_axis_data_tready, output, 1: block can accept a sample.
REQ-007 SHALL have port s_axis_data_tdata, input, DATA_W: filtered sample from the FIR stage.
REQ-008 SHALL have port m_axis_data_tvalid, output, 1: decimated sample valid.
REQ-009 SHALL have port m_axis_data_tready, input, 1: downstream accepts the decimated sample.
REQ-010 SHALL have port m_axis_data_tdata, output, DATA_W: decimated, averaged sample.
REQ-011 SHALL have port out_count, output, 16: number of decimated words transferred, wrapping.

Function
REQ-012 SHALL treat an input transfer as s_axis_data_tvalid && s_axis_data_tready at a rising aclk edge; an output transfer as m_axis_data_tvalid && m_axis_data_tready.
REQ-013 SHALL drive s_axis_data_tready = !m_axis_data_tvalid || m_axis_data_tready (combinational pass-through permitted; no other stall source).
REQ-014 SHALL keep a phase counter 0..DECIM-1 and a signed accumulator of DATA_W+log2(DECIM) bits; each input transfer adds the sign-extended sample and increments the counter.
REQ-015 SHALL, on the input transfer with counter == DECIM-1, compute (accumulator + sample + 2^(log2(DECIM)-1)) arithmetic-shifted right by log2(DECIM), load it into the output register, set m_axis_data_tvalid, clear accumulator to 0 and counter to 0, all at that same edge.
REQ-016 SHALL therefore present the decimated word one cycle after the edge accepting the group's last sample; no other latency.
REQ-017 SHALL saturate the shifted result to [-2^(DATA_W-1), 2^(DATA_W-1)-1] (defensive; not reachable for legal inputs).
REQ-018 SHALL hold m_axis_data_tdata and m_axis_data_tvalid stable while m_axis_data_tvalid && !m_axis_data_tready.
REQ-019 SHALL clear m_axis_data_tvalid after an output transfer unless a new group completes on the same edge, in which case the new word loads with m_axis_data_tvalid kept at 1 (no bubble).
REQ-020 SHALL ignore s_axis_data_tdata when no input transfer occurs; counter and accumulator unchanged.
REQ-021 SHALL increment out_count by 1 (mod 2^16) on every output transfer.
REQ-022 SHALL sustain one input per cycle while downstream keeps m_axis_data_tready high.

Reset
REQ-023 SHALL, while aresetn is low, force counter=0, accumulator=0, m_axis_data_tvalid=0, m_axis_data_tdata=0, out_count=0, independent of aclk.
REQ-024 SHALL discard any partially accumulated group and any unconsumed output word on reset; the first group after release starts at phase 0.
REQ-025 SHALL drive s_axis_data_tready=1 during and immediately after reset.

Verification (DECIM=4, DATA_W=16)
REQ-026 SHALL cover: inputs 100,200,300,400 back-to-back, m_tready=1 -> one output 250, m_tvalid high exactly 1 cycle, out_count=1.
REQ-027 SHALL cover: inputs -1,-1,-1,-2 -> output -1 (sum -5, +2, >>>2); inputs 1,1,1,2 -> output 1.
REQ-028 SHALL cover: four inputs 32767 then four inputs -32768 -> outputs 32767 then -32768, no wrap.
REQ-029 SHALL cover: m_tready=0 with output 250 pending -> s_tready=0, m_tdata stays 250 for 10 cycles, group sums unaffected; release -> transfer, out_count+1.
REQ-030 SHALL cover: 3 samples of 1000 then aresetn low mid-cycle for 2 cycles, then 4 samples of 8 -> single output 8, m_tvalid low during reset.
REQ-031 SHALL cover: continuous input stream with m_tready=1, 16 samples ramp 0..15 -> outputs 2,6,10,14 (rounded averages 1.5->2, 5.5->6, ...) with no gaps, out_count=4.
